ritc_auto_train: RTL and testbench
==================================

Name: ritc_auto_train

Overview:
Parametrised automatic deserializer alignment controller for the RITC digitizer inputs. It replaces the manual training-select / bitslip register path in the RITC controller with a hardware sweep. Every lane (channel x bit) is selected in turn. Its SYNC-framed training word is captured and compared against the expected pattern, and bitslip pulses are issued until the lane locks or exhausts its slip budget. Per-lane slip counts and a fail map are reported back to the user register interface.

Parameters:
NCH, 3, number of RITC channels
NBITS, 12, data bits per channel
NSAMP, 4, deserialized samples per bit per CLK; training word is 2*NSAMP bits
PATTERN, 8'hF0, expected training word {SYNC-low half, SYNC-high half}; width 2*NSAMP
MATCH_COUNT, 16, consecutive matching words required for lock (1..255)
MAX_SLIP, 7, bitslips allowed per lane before fail (<=15)
SETTLE_CYC, 7, CLK cycles to wait after each bitslip pulse
WORD_TIMEOUT, 64, CLK cycles without a complete word before a sync error is declared

Ports:
CLK  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start strobe; ignored while busy_o=1
SYNC  in  1  RITC sync (half-rate framing)
data_i  in  NCH*NBITS*NSAMP  deserialized data; sample s of bit b of channel c is at c*NBITS*NSAMP + s*NBITS + b
bitslip_o  out  1  one-cycle bitslip pulse to the ISERDES of the selected lane
bitslip_addr_o  out  6  selected lane {ch[1:0],bit[3:0]}
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse at sweep end
fail_o  out  1  sticky: at least one lane failed in the last sweep
sync_err_o  out  1  sticky: word timeout occurred in the last sweep
fail_map_o  out  NCH*NBITS  per-lane fail flags, index c*NBITS+b
stat_addr_i  in  6  lane address for status readback
stat_dat_o  out  8  registered {lock,fail,2'b0,slip_count[3:0]} of the addressed lane; 1-cycle latency

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, status RAM cleared (flop array, cleared on reset).
- Data path: data_i registered, then lane-muxed (2-cycle latency), then NSAMP bits presented. Half-word is captured while SYNC=1 into the low half and while SYNC=0 into the high half. A word is complete on a SYNC=0 cycle that directly follows a SYNC=1 cycle.
- FSM states:
  - IDLE: start_i moves to CLEAR.
  - CLEAR: clears fail_map_o, fail_o, sync_err_o and status; lane=0.
  - SELECT: drives bitslip_addr_o; waits 4 cycles for pipeline fill.
  - COMPARE: evaluates each complete word.
    - match: match_cnt+1; reaching MATCH_COUNT moves to NEXT with lock=1.
    - mismatch: match_cnt=0. If slip_cnt==MAX_SLIP, fail the lane and go to NEXT. Otherwise go to SLIP.
  - SLIP: bitslip_o=1 for exactly 1 cycle, slip_cnt+1.
  - SETTLE: waits SETTLE_CYC cycles, then returns to COMPARE; words completing during SETTLE are discarded.
  - NEXT: writes status; if lane is the last lane go to DONE, else advance lane and go to SELECT.
  - DONE: done_o pulse, then IDLE.
- Lane advance skips unused addresses: bit wraps from NBITS-1 to 0 with ch+1. Sweep ends after ch=NCH-1, bit=NBITS-1.
- match_cnt and slip_cnt reset to 0 at every SELECT.
- Word timeout: no complete word for WORD_TIMEOUT cycles in COMPARE sets sync_err_o, fails the lane (lock=0, fail=1), and goes to NEXT.
- A lane that locks with 0 slips reports slip_count=0, lock=1.
- busy_o=1 in every state except IDLE.
- start_i arriving in the same cycle as done_o is ignored.
- Reset mid-sweep aborts immediately; bitslip_o is deasserted asynchronously.
- stat_addr_i values beyond the last lane read 8'h00.

Optional Feature:
RITC_TRAIN_SKIPMASK_EN: adds input skip_mask_i [NCH*NBITS]. Masked lanes go directly from SELECT to NEXT without issuing a bitslip. They record status 8'h00 and their fail_map_o bit stays 0. Without the macro, all lanes are trained and no skip_mask_i port exists.

Test Plan:
- Aligned lanes: all lanes present PATTERN 8'hF0 from the first word. Expect 0 bitslip pulses, done_o after the sweep, fail_map_o=0, every stat_dat_o=8'h80.
- Lane (1,5) rotated by 3: the model rotates on each bitslip. Expect exactly 3 pulses with bitslip_addr_o=6'h15 and stat_dat_o(6'h15)=8'h83.
- Lane (2,0) never matches: expect MAX_SLIP=7 pulses, then fail_map_o bit 24=1, fail_o=1, stat_dat_o(6'h20)=8'h47; the sweep continues to completion.
- SYNC held low for 100 cycles on lane (0,0): expect sync_err_o=1, fail_map_o bit 0=1, and the sweep proceeds to lane (0,1).
- Reset asserted during SETTLE of lane (0,3): expect all outputs 0 asynchronously; a new start_i gives a full sweep from lane 0.
- With RITC_TRAIN_SKIPMASK_EN and skip_mask_i bit 2 set, lane (0,2) otherwise failing: expect no pulses at address 6'h02, stat 8'h00, fail_o=0.

Source files
------------

// File: rtl/ritc_auto_train.sv
// Automatic ISERDES bitslip alignment sweep for the RITC digitizer lanes.
// Optional macro RITC_TRAIN_SKIPMASK_EN adds skip_mask_i to bypass selected lanes.
module ritc_auto_train #(
  parameter int unsigned NCH          = 3,
  parameter int unsigned NBITS        = 12,
  parameter int unsigned NSAMP        = 4,
  parameter logic [2*NSAMP-1:0] PATTERN = 8'hF0,
  parameter int unsigned MATCH_COUNT  = 16,
  parameter int unsigned MAX_SLIP     = 7,
  parameter int unsigned SETTLE_CYC   = 7,
  parameter int unsigned WORD_TIMEOUT = 64
) (
  input  logic                         CLK,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         SYNC,
  input  logic [NCH*NBITS*NSAMP-1:0]   data_i,
`ifdef RITC_TRAIN_SKIPMASK_EN
  input  logic [NCH*NBITS-1:0]         skip_mask_i,
`endif
  output logic                         bitslip_o,
  output logic [5:0]                   bitslip_addr_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         fail_o,
  output logic                         sync_err_o,
  output logic [NCH*NBITS-1:0]         fail_map_o,
  input  logic [5:0]                   stat_addr_i,
  output logic [7:0]                   stat_dat_o
);

  localparam int unsigned NLANE = NCH * NBITS;
  localparam int unsigned DW    = NLANE * NSAMP;
  localparam int unsigned LW    = $clog2(NLANE);
  localparam int unsigned DIW   = $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SELECT, S_COMPARE, S_SLIP, S_SETTLE, S_NEXT, S_DONE
  } state_t;

  state_t               state;
  logic [1:0]           ch_r;
  logic [3:0]           bt_r;
  logic [15:0]          wait_cnt;
  logic [7:0]           match_cnt;
  logic [3:0]           slip_cnt;
  logic                 lane_lock, lane_fail;
  logic [7:0]           stat_mem [NLANE];

  logic [DW-1:0]        data_r;
  logic [NSAMP-1:0]     samp_r, lo_r;
  logic                 sync_d1, sync_d2, sync_d3;
  logic                 word_vld;
  logic [2*NSAMP-1:0]   word_r;

  logic [31:0]          lane_off;
  logic [LW-1:0]        lane_idx;
  logic                 last_lane;
  logic                 lane_skip;
  logic                 rd_ok;
  logic [LW-1:0]        rd_idx;

  assign bitslip_addr_o = {ch_r, bt_r};

  always_comb begin
    lane_off  = 32'(ch_r) * NBITS * NSAMP + 32'(bt_r);
    lane_idx  = LW'(32'(ch_r) * NBITS + 32'(bt_r));
    last_lane = (32'(ch_r) == NCH - 1) && (32'(bt_r) == NBITS - 1);
    rd_ok     = (32'(stat_addr_i[5:4]) < NCH) && (32'(stat_addr_i[3:0]) < NBITS);
    rd_idx    = LW'(32'(stat_addr_i[5:4]) * NBITS + 32'(stat_addr_i[3:0]));
  end

`ifdef RITC_TRAIN_SKIPMASK_EN
  assign lane_skip = skip_mask_i[lane_idx];
`else
  assign lane_skip = 1'b0;
`endif

  // SYNC is delayed alongside the data so framing stays aligned with the muxed samples.
  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_r   <= '0;
      samp_r   <= '0;
      lo_r     <= '0;
      sync_d1  <= 1'b0;
      sync_d2  <= 1'b0;
      sync_d3  <= 1'b0;
      word_vld <= 1'b0;
      word_r   <= '0;
    end else begin
      data_r  <= data_i;
      sync_d1 <= SYNC;
      sync_d2 <= sync_d1;
      sync_d3 <= sync_d2;
      for (int unsigned s = 0; s < NSAMP; s++)
        samp_r[s] <= data_r[DIW'(lane_off + s * NBITS)];
      if (sync_d2)
        lo_r <= samp_r;
      word_vld <= !sync_d2 && sync_d3;
      word_r   <= {samp_r, lo_r};
    end
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      ch_r       <= '0;
      bt_r       <= '0;
      wait_cnt   <= '0;
      match_cnt  <= '0;
      slip_cnt   <= '0;
      lane_lock  <= 1'b0;
      lane_fail  <= 1'b0;
      bitslip_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      fail_o     <= 1'b0;
      sync_err_o <= 1'b0;
      fail_map_o <= '0;
      for (int unsigned l = 0; l < NLANE; l++)
        stat_mem[l] <= '0;
    end else begin
      bitslip_o <= 1'b0;
      done_o    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          fail_map_o <= '0;
          fail_o     <= 1'b0;
          sync_err_o <= 1'b0;
          for (int unsigned l = 0; l < NLANE; l++)
            stat_mem[l] <= '0;
          ch_r     <= '0;
          bt_r     <= '0;
          wait_cnt <= '0;
          state    <= S_SELECT;
        end
        S_SELECT: begin
          match_cnt <= '0;
          slip_cnt  <= '0;
          lane_lock <= 1'b0;
          lane_fail <= 1'b0;
          if (wait_cnt == 16'd3) begin
            wait_cnt <= '0;
            state    <= lane_skip ? S_NEXT : S_COMPARE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_COMPARE: begin
          if (word_vld) begin
            wait_cnt <= '0;
            if (word_r == PATTERN) begin
              if (match_cnt == 8'(MATCH_COUNT - 1)) begin
                lane_lock <= 1'b1;
                state     <= S_NEXT;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
              if (slip_cnt == 4'(MAX_SLIP)) begin
                lane_fail <= 1'b1;
                state     <= S_NEXT;
              end else begin
                state <= S_SLIP;
              end
            end
          end else if (wait_cnt == 16'(WORD_TIMEOUT - 1)) begin
            sync_err_o <= 1'b1;
            lane_fail  <= 1'b1;
            state      <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_SLIP: begin
          bitslip_o <= 1'b1;
          slip_cnt  <= slip_cnt + 4'd1;
          wait_cnt  <= '0;
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (wait_cnt == 16'(SETTLE_CYC - 1)) begin
            wait_cnt <= '0;
            state    <= S_COMPARE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_NEXT: begin
          stat_mem[lane_idx]   <= {lane_lock, lane_fail, 2'b00, slip_cnt};
          fail_map_o[lane_idx] <= lane_fail;
          if (lane_fail)
            fail_o <= 1'b1;
          wait_cnt <= '0;
          if (last_lane) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            if (32'(bt_r) == NBITS - 1) begin
              bt_r <= '0;
              ch_r <= ch_r + 2'd1;
            end else begin
              bt_r <= bt_r + 4'd1;
            end
            state <= S_SELECT;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i)
      stat_dat_o <= '0;
    else
      stat_dat_o <= rd_ok ? stat_mem[rd_idx] : '0;
  end

endmodule

// File: tb/tb_ritc_auto_train.sv
// Scoreboard bench for ritc_auto_train: per-lane ISERDES rotation model, sweep
// expectations queued at start, monitor checks on done_o and on status readback.
module tb_ritc_auto_train;
  localparam int NCH = 3, NBITS = 12, NSAMP = 4, NL = NCH * NBITS, MAX_SLIP = 7;
  localparam logic [7:0] PAT = 8'hF0, BADW = 8'hAA;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                        rst_n, start_i, SYNC;
  logic [NCH*NBITS*NSAMP-1:0]  data_i;
  logic                        bitslip_o, busy_o, done_o, fail_o, sync_err_o;
  logic [5:0]                  bitslip_addr_o, stat_addr_i;
  logic [NL-1:0]               fail_map_o;
  logic [7:0]                  stat_dat_o;
`ifdef RITC_TRAIN_SKIPMASK_EN
  logic [NL-1:0]               skip_mask;
`endif

  ritc_auto_train #(
    .NCH(NCH), .NBITS(NBITS), .NSAMP(NSAMP), .PATTERN(PAT),
    .MATCH_COUNT(16), .MAX_SLIP(MAX_SLIP), .SETTLE_CYC(7), .WORD_TIMEOUT(64)
  ) dut (
    .CLK(CLK), .rst_n_i(rst_n), .start_i(start_i), .SYNC(SYNC), .data_i(data_i),
`ifdef RITC_TRAIN_SKIPMASK_EN
    .skip_mask_i(skip_mask),
`endif
    .bitslip_o(bitslip_o), .bitslip_addr_o(bitslip_addr_o), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .sync_err_o(sync_err_o),
    .fail_map_o(fail_map_o), .stat_addr_i(stat_addr_i), .stat_dat_o(stat_dat_o)
  );

  typedef struct {
    logic [NL-1:0] fmap;
    logic          fail;
    logic          serr;
    logic [7:0]    stat [NL];
  } exp_t;

  int   rot [NL];
  bit   bad [NL];
  bit   tmo [NL];
  bit   skp [NL];
  int   pulses [NL];
  int   hold_low = 0;
  bit   rd_req = 0, rd_prev = 0;
  int   n_cmp = 0, n_bad = 0;
  int   cc, bb, ln;
  exp_t exp_q [$];
  exp_t last_exp, mon_e;
  logic [7:0] stat_q [$];

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int r);
    int rr;
    rr = r & 7;
    return (w << rr) | (w >> (8 - rr));
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: a lane locks after the fewest slips that rotate its word onto PAT.
  task automatic compute_exp(output exp_t e);
    e.fmap = '0;
    e.fail = 1'b0;
    e.serr = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (skp[l]) begin
        e.stat[l] = 8'h00;
      end else if (tmo[l]) begin
        e.stat[l] = 8'h40;
        e.fmap[l] = 1'b1;
        e.fail    = 1'b1;
        e.serr    = 1'b1;
      end else begin
        int k;
        logic [7:0] base;
        k = -1;
        base = bad[l] ? BADW : PAT;
        for (int j = 0; j <= MAX_SLIP; j++)
          if (k < 0 && rotl8(base, rot[l] - j + 8) == PAT) k = j;
        if (k >= 0) begin
          e.stat[l] = 8'h80 | 8'(k);
        end else begin
          e.stat[l] = 8'h40 | 8'(MAX_SLIP);
          e.fmap[l] = 1'b1;
          e.fail    = 1'b1;
        end
      end
    end
  endtask

  // Source: SYNC toggles every cycle; each lane presents its rotated word by SYNC phase.
  initial begin
    logic [7:0] w;
    SYNC = 1'b0;
    data_i = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (hold_low > 0) begin
        SYNC = 1'b0;
        hold_low--;
      end else begin
        SYNC = ~SYNC;
      end
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < NBITS; b++) begin
          w = rotl8(bad[c*NBITS+b] ? BADW : PAT, rot[c*NBITS+b]);
          for (int s = 0; s < NSAMP; s++)
            data_i[c*NBITS*NSAMP + s*NBITS + b] = SYNC ? w[s] : w[NSAMP+s];
        end
    end
  end

  // Monitor: ISERDES slip model, pulse counting, sweep and readback scoreboards.
  always @(negedge CLK) begin
    if (rd_prev) begin
      if (stat_q.size() == 0) check("stat_q_empty", 1, 0);
      else check("stat_dat", stat_dat_o, stat_q.pop_front());
    end
    rd_prev = rd_req;
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) pulses[l] = 0;
    end else begin
      if (start_i && !busy_o)
        for (int l = 0; l < NL; l++) pulses[l] = 0;
      if (bitslip_o) begin
        cc = int'(bitslip_addr_o[5:4]);
        bb = int'(bitslip_addr_o[3:0]);
        if (cc < NCH && bb < NBITS) begin
          ln = cc * NBITS + bb;
          pulses[ln]++;
          rot[ln] = (rot[ln] + 7) % 8;
        end else begin
          check("slip_addr_range", bitslip_addr_o, 0);
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done_o, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("fail_map", fail_map_o, mon_e.fmap);
          check("fail_o", fail_o, mon_e.fail);
          check("sync_err_o", sync_err_o, mon_e.serr);
          for (int l = 0; l < NL; l++)
            check($sformatf("pulses_lane%0d", l), pulses[l], mon_e.stat[l][3:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_sweep(input int budget);
    exp_t e;
    int cyc;
    compute_exp(e);
    exp_q.push_back(e);
    last_exp = e;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!done_o) begin
      check("done_timeout", done_o, 1);
      exp_q.delete();
    end else begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      check("start_in_done_ignored", busy_o, 0);
    end
  endtask

  task automatic readback();
    for (int a = 0; a < 64; a++) begin
      int c, b;
      c = a >> 4;
      b = a & 15;
      stat_addr_i = 6'(a);
      stat_q.push_back((c < NCH && b < NBITS) ? last_exp.stat[c*NBITS+b] : 8'h00);
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_bitslip"}, bitslip_o, 0);
    check({tag, "_addr"}, bitslip_addr_o, 0);
    check({tag, "_fail"}, fail_o, 0);
    check({tag, "_serr"}, sync_err_o, 0);
    check({tag, "_fmap"}, fail_map_o, 0);
    check({tag, "_stat"}, stat_dat_o, 0);
  endtask

  initial begin
    exp_t e;
    int cyc;
    rst_n = 1'b0;
    start_i = 1'b0;
    stat_addr_i = '0;
`ifdef RITC_TRAIN_SKIPMASK_EN
    skip_mask = '0;
`endif
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // all lanes aligned
    run_sweep(8000);
    readback();

    // lane (1,5) rotated by 3, lane (2,0) never matches
    rot[17] = 3;
    bad[24] = 1'b1;
    run_sweep(8000);
    readback();

    // randomized rotations and dead lanes
    repeat (2) begin
      for (int l = 0; l < NL; l++) begin
        bad[l] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) rot[l] = int'($urandom_range(0, 7));
      end
      run_sweep(8000);
      readback();
    end

    // SYNC stuck low across lane (0,0)
    for (int l = 0; l < NL; l++) bad[l] = 1'b0;
    tmo[0] = 1'b1;
    hold_low = 100;
    run_sweep(8000);
    readback();
    tmo[0] = 1'b0;

    // reset during SETTLE of lane (0,3), then a fresh full sweep
    rot[3] = 2;
    compute_exp(e);
    exp_q.push_back(e);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (!(bitslip_o && bitslip_addr_o == 6'h03) && cyc < 8000) begin
      tick();
      cyc++;
    end
    check("lane3_slip_seen", bitslip_o && bitslip_addr_o == 6'h03, 1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_sweep(8000);
    readback();

`ifdef RITC_TRAIN_SKIPMASK_EN
    // masked failing lane (0,2)
    bad[2] = 1'b1;
    skp[2] = 1'b1;
    skip_mask = '0;
    skip_mask[2] = 1'b1;
    run_sweep(8000);
    readback();
    check("skip_fail_o", fail_o, 0);
    skip_mask = '0;
    skp[2] = 1'b0;
    bad[2] = 1'b0;
`endif

    repeat (5) tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached (compared %0d, failed %0d)", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
